// File: rtl/video_sched_pkg.sv
// video_sched_pkg: shared types and constants for the video-slot write scheduler.
package video_sched_pkg;
    localparam int MAX_SW = 8;
    localparam logic [13:0] BYPASS_REG_ADDR = 14'd0;
    localparam logic [31:0] BYPASS_ON = 32'h1;
    localparam logic [31:0] BYPASS_OFF = 32'h0;
    typedef struct packed {
        logic [MAX_SW-1:0] slot;
        logic [13:0]       addr;
        logic [31:0]       data;
    } slot_wr_t;
    typedef enum logic [1:0] {IDLE, DRAIN, AUTO_OFF, AUTO_ON} state_t;
endpackage

// File: rtl/slot_wr_fifo.sv
// slot_wr_fifo: synchronous FIFO of pending slot writes with full/empty flags.
module slot_wr_fifo
    import video_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  slot_wr_t din,
    output slot_wr_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    slot_wr_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[rp];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/video_slot_scheduler.sv
// video_slot_scheduler: queues host video-slot writes and releases them only during vertical blanking.
// Autonomous bypass cycling across slots is built only when VIDEO_SCHED_AUTO_EN is defined.
module video_slot_scheduler
    import video_sched_pkg::*;
#(
    parameter int NUM_SLOTS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int V_ACTIVE     = 480,
    parameter int DWELL_FRAMES = 60,
    localparam int SW          = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          x,
    input  logic [10:0]          y,
    input  logic                 host_write,
    input  logic [SW-1:0]        host_slot,
    input  logic [13:0]          host_addr,
    input  logic [31:0]          host_wr_data,
    output logic                 host_ready,
    output logic                 ovf,
    input  logic                 auto_en,
    input  logic [NUM_SLOTS-1:0] auto_mask,
    output logic [NUM_SLOTS-1:0] slot_cs,
    output logic                 slot_write,
    output logic [13:0]          slot_addr,
    output logic [31:0]          slot_wr_data
);
    slot_wr_t req, head, ent;
    state_t state, state_n;
    logic full, empty, pop, issue, vblank, auto_pend;
    logic [SW-1:0] cur_slot, nxt_slot;
    assign vblank = y >= 11'(V_ACTIVE);
    assign host_ready = !full;
    assign req = '{slot: MAX_SW'(host_slot), addr: host_addr, data: host_wr_data};
    slot_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(host_write), .pop(pop),
        .din(req), .dout(head), .full(full), .empty(empty)
    );
`ifdef VIDEO_SCHED_AUTO_EN
    localparam int FW = $clog2(DWELL_FRAMES + 1);
    logic [FW-1:0] frame_cnt;
    logic vbs, nxt_ok, wrap;
    logic [SW-1:0] k;
    assign wrap = vbs && frame_cnt == FW'(DWELL_FRAMES - 1);
    // Smallest offset wins: scanning downward leaves the nearest set bit above cur_slot.
    always_comb begin
        nxt_slot = cur_slot;
        nxt_ok = 1'b0;
        k = '0;
        for (int i = NUM_SLOTS - 1; i >= 1; i--) begin
            k = SW'((int'(cur_slot) + i) % NUM_SLOTS);
            if (auto_mask[k]) begin
                nxt_slot = k;
                nxt_ok = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vbs <= 1'b0;
            frame_cnt <= '0;
            auto_pend <= 1'b0;
            cur_slot <= '0;
        end else begin
            vbs <= y == 11'(V_ACTIVE) && x == 11'd0;
            frame_cnt <= (!auto_en || wrap) ? '0 : vbs ? frame_cnt + 1'b1 : frame_cnt;
            auto_pend <= auto_en && nxt_ok && state != AUTO_ON && (auto_pend || wrap);
            if (state == AUTO_ON) cur_slot <= nxt_slot;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = &{1'b0, auto_en, auto_mask};
    assign auto_pend = 1'b0;
    assign cur_slot = '0;
    assign nxt_slot = '0;
`endif
    always_comb begin
        state_n = state;
        pop = 1'b0;
        issue = 1'b0;
        ent = head;
        case (state)
            IDLE: state_n = !vblank ? IDLE : !empty ? DRAIN : auto_pend ? AUTO_OFF : IDLE;
            DRAIN: begin
                pop = vblank && !empty;
                issue = pop;
                state_n = !vblank ? IDLE : !empty ? DRAIN : auto_pend ? AUTO_OFF : IDLE;
            end
            AUTO_OFF: begin
                issue = vblank;
                ent = '{slot: MAX_SW'(cur_slot), addr: BYPASS_REG_ADDR, data: BYPASS_ON};
                state_n = vblank ? AUTO_ON : IDLE;
            end
            AUTO_ON: begin
                // Completes the pair even if blanking just ended, so a slot is never left bypassed alone.
                issue = 1'b1;
                ent = '{slot: MAX_SW'(nxt_slot), addr: BYPASS_REG_ADDR, data: BYPASS_OFF};
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ovf <= 1'b0;
            slot_cs <= '0;
            slot_write <= 1'b0;
            slot_addr <= '0;
            slot_wr_data <= '0;
        end else begin
            state <= state_n;
            ovf <= ovf || (host_write && full);
            slot_write <= issue;
            slot_cs <= issue ? NUM_SLOTS'(1) << ent.slot : '0;
            if (issue) begin
                slot_addr <= ent.addr;
                slot_wr_data <= ent.data;
            end
        end
    end
endmodule

// File: tb/tb_video_slot_scheduler.sv
// tb_video_slot_scheduler: directed scoreboard bench for the vblank-gated slot write scheduler.
module tb_video_slot_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [10:0] x = '0, y = '0;
    logic host_write = 1'b0;
    logic [2:0] host_slot = '0;
    logic [13:0] host_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic host_ready, ovf;
    logic auto_en = 1'b0;
    logic [7:0] auto_mask = '0;
    logic [7:0] slot_cs;
    logic slot_write;
    logic [13:0] slot_addr;
    logic [31:0] slot_wr_data;
    int checks = 0, errors = 0, nwr = 0, base = 0;
    logic [53:0] exp_q[$];

    video_slot_scheduler #(.DWELL_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .host_write(host_write), .host_slot(host_slot), .host_addr(host_addr),
        .host_wr_data(host_wr_data), .host_ready(host_ready), .ovf(ovf),
        .auto_en(auto_en), .auto_mask(auto_mask), .slot_cs(slot_cs),
        .slot_write(slot_write), .slot_addr(slot_addr), .slot_wr_data(slot_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [2:0] s, input logic [13:0] a, input logic [31:0] d, input bit keep);
        logic [7:0] cs;
        cs = 8'd1 << s;
        host_write = 1'b1;
        host_slot = s;
        host_addr = a;
        host_wr_data = d;
        if (keep) exp_q.push_back({cs, a, d});
        tick(1);
        host_write = 1'b0;
    endtask

    task automatic enter_vblank();
        y = 11'd480;
        x = 11'd0;
        tick(1);
        x = 11'd1;
    endtask

    task automatic frame();
        enter_vblank();
        tick(6);
        y = 11'd0;
        tick(4);
    endtask

    always @(negedge clk) begin
        if (!reset && slot_write) begin
            nwr++;
            if (exp_q.size() == 0) chk("unexpected_write", 64'(exp_q.size()), 64'd1);
            else chk("write", {slot_cs, slot_addr, slot_wr_data}, exp_q.pop_front());
        end
    end

    initial begin
        // reset state
        #1;
        chk("rst_cs", slot_cs, 0);
        chk("rst_write", slot_write, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("idle_cs", slot_cs, 0);
        chk("idle_write", slot_write, 0);
        chk("idle_addr", slot_addr, 0);
        chk("idle_data", slot_wr_data, 0);
        chk("idle_ready", host_ready, 1);
        chk("idle_ovf", ovf, 0);

        // single write held until vblank, 2-clk latency
        y = 11'd100;
        host_wr(3'd2, 14'd0, 32'd1, 1'b1);
        tick(5);
        chk("held_until_vblank", nwr, 0);
        enter_vblank();
        chk("latency_early", slot_write, 0);
        tick(1);
        chk("latency_issue", slot_write, 1);
        chk("latency_cs", slot_cs, 8'b0000_0100);
        tick(1);
        chk("pulse_end", slot_write, 0);
        tick(2);
        y = 11'd0;
        tick(3);
        chk("t2_count", nwr, 1);

        // overflow and back-to-back drain
        y = 11'd100;
        for (int i = 0; i < 5; i++) begin
            host_wr(3'(2 * i + 1), 14'(16 + i), 32'hA000_0000 + 32'(i), i < 4);
            chk("ready_after_push", host_ready, i < 3);
            chk("ovf_after_push", ovf, i == 4);
        end
        base = nwr;
        enter_vblank();
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("burst_write", slot_write, 1);
        end
        tick(1);
        chk("burst_end", slot_write, 0);
        chk("burst_count", nwr - base, 4);
        chk("ready_after_drain", host_ready, 1);
        chk("ovf_sticky", ovf, 1);
        y = 11'd0;
        tick(3);

        // vblank ends mid-drain
        y = 11'd100;
        for (int i = 0; i < 4; i++) host_wr(3'(i + 4), 14'(100 + i), 32'h5500_0000 + 32'(i), 1'b1);
        base = nwr;
        enter_vblank();
        tick(2);
        y = 11'd0;
        tick(1);
        chk("split_stop", slot_write, 0);
        tick(5);
        chk("split_first_half", nwr - base, 2);
        enter_vblank();
        tick(2);
        tick(1);
        chk("split_end", slot_write, 0);
        chk("split_total", nwr - base, 4);
        chk("split_ready", host_ready, 1);
        y = 11'd0;
        tick(3);

        // reset mid-issue aborts the strobe and empties the FIFO
        y = 11'd100;
        host_wr(3'd1, 14'd7, 32'hDEAD, 1'b0);
        host_wr(3'd6, 14'd8, 32'hBEEF, 1'b0);
        base = nwr;
        enter_vblank();
        tick(1);
        chk("pre_reset_write", slot_write, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_write", slot_write, 0);
        chk("async_rst_cs", slot_cs, 0);
        chk("async_rst_ovf", ovf, 0);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("rst_fifo_empty", nwr - base, 0);
        chk("rst_ready", host_ready, 1);
        y = 11'd0;
        tick(3);

        auto_en = 1'b1;
        auto_mask = 8'b0000_0101;
        base = nwr;
`ifdef VIDEO_SCHED_AUTO_EN
        // autonomous cycling with DWELL_FRAMES=2
        frame();
        chk("auto_f1_quiet", nwr - base, 0);
        exp_q.push_back({8'b0000_0001, 14'd0, 32'h1});
        exp_q.push_back({8'b0000_0100, 14'd0, 32'h0});
        frame();
        chk("auto_f2_pair", nwr - base, 2);
        frame();
        chk("auto_f3_quiet", nwr - base, 2);
        exp_q.push_back({8'b0000_0100, 14'd0, 32'h1});
        exp_q.push_back({8'b0000_0001, 14'd0, 32'h0});
        frame();
        chk("auto_f4_pair", nwr - base, 4);
        // single-slot mask never writes
        auto_mask = 8'b0000_0001;
        frame();
        frame();
        chk("auto_single_quiet", nwr - base, 4);
        // host entry takes priority over the auto pair
        auto_mask = 8'b0000_0101;
        frame();
        chk("auto_f7_quiet", nwr - base, 4);
        y = 11'd100;
        host_wr(3'd3, 14'd9, 32'h1234, 1'b1);
        exp_q.push_back({8'b0000_0001, 14'd0, 32'h1});
        exp_q.push_back({8'b0000_0100, 14'd0, 32'h0});
        frame();
        chk("auto_priority", nwr - base, 7);
`else
        frame();
        frame();
        frame();
        chk("no_auto_quiet", nwr - base, 0);
`endif
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
